// File: rtl/obd_telemetry_tx.sv
// Snapshots vehicle telemetry and sends it as a fixed binary frame over an 8N1 UART line.
// Define OBD_CHECKSUM_EN to append an XOR checksum byte (13-byte frame instead of 12).
module obd_telemetry_tx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int PERIOD_TICKS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1sec,
  input  logic        req,
  input  logic [3:0]  current_gear,
  input  logic [7:0]  speed,
  input  logic [13:0] rpm,
  input  logic [7:0]  fuel,
  input  logic [7:0]  temp,
  input  logic [31:0] odometer_raw,
  input  logic        ess_trigger,
  output logic        txd,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  // BAUD_DIV must be at least 2 for the bit timer to behave.
  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(BAUD_DIV - 1);

`ifdef OBD_CHECKSUM_EN
  localparam int NBYTES = 13;
`else
  localparam int NBYTES = 12;
`endif
  localparam logic [3:0] LAST_BYTE   = 4'(NBYTES - 1);
  localparam logic [7:0] PERIOD_LAST = 8'(PERIOD_TICKS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [3:0]    byte_idx, byte_nxt;
  logic [7:0]    tick_cnt;
  logic          pending;
  logic          ess_latch;
  logic          auto_trig;
  logic          trig;
  logic          bit_end;
  logic          frame_start;
  logic          txd_nxt;
  logic          busy_nxt;
  logic [7:0]    frame_in [16];
  logic [7:0]    snap     [16];
  logic [7:0]    cur_byte;

  assign auto_trig = tick_1sec && (tick_cnt == PERIOD_LAST);
  assign trig      = auto_trig || req;
  assign bit_end   = (baud_cnt == DIV_LAST);
  assign cur_byte  = snap[byte_idx];

  // Frame image as it would be captured this cycle; slots past NBYTES-1 stay zero.
  always_comb begin
    for (int i = 0; i < 16; i++) frame_in[i] = 8'h00;
    frame_in[0]  = 8'hA5;
    frame_in[1]  = {4'b0000, current_gear};
    frame_in[2]  = speed;
    frame_in[3]  = {2'b00, rpm[13:8]};
    frame_in[4]  = rpm[7:0];
    frame_in[5]  = fuel;
    frame_in[6]  = temp;
    frame_in[7]  = odometer_raw[31:24];
    frame_in[8]  = odometer_raw[23:16];
    frame_in[9]  = odometer_raw[15:8];
    frame_in[10] = odometer_raw[7:0];
    frame_in[11] = {6'b000000, ess_latch | ess_trigger, ess_trigger};
`ifdef OBD_CHECKSUM_EN
    frame_in[12] = 8'h00;
    for (int i = 1; i < 12; i++) frame_in[12] = frame_in[12] ^ frame_in[i];
`endif
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      byte_idx <= byte_nxt;
      txd      <= txd_nxt;
      busy     <= busy_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud_cnt;
    bit_nxt     = bit_idx;
    byte_nxt    = byte_idx;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          frame_start = 1'b1;
          state_nxt   = START;
          baud_nxt    = '0;
          byte_nxt    = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          baud_nxt  = '0;
          bit_nxt   = '0;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_idx + 3'd1;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (byte_idx != LAST_BYTE) begin
            byte_nxt  = byte_idx + 4'd1;
            state_nxt = START;
          end else if (pending || trig) begin
            // Back-to-back frame: no idle bit between frames.
            frame_start = 1'b1;
            byte_nxt    = '0;
            state_nxt   = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic, evaluated on the upcoming state so txd/busy come straight from flops
  always_comb begin
    txd_nxt  = 1'b1;
    busy_nxt = (state_nxt != IDLE);
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = cur_byte[bit_nxt];
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) snap[i] <= 8'h00;
      frame_cnt <= 16'h0000;
    end else if (frame_start) begin
      for (int i = 0; i < 16; i++) snap[i] <= frame_in[i];
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt  <= 8'h00;
      pending   <= 1'b0;
      ess_latch <= 1'b0;
    end else begin
      if (tick_1sec) tick_cnt <= auto_trig ? 8'h00 : tick_cnt + 8'd1;
      // Any number of triggers during a frame collapse into one follow-on frame.
      if (frame_start) pending <= 1'b0;
      else if (trig)   pending <= 1'b1;
      if (frame_start)      ess_latch <= ess_trigger;
      else if (ess_trigger) ess_latch <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obd_telemetry_tx.sv
// Directed bench for obd_telemetry_tx: UART decoder plus per-scenario tasks.
module tb_obd_telemetry_tx;

`ifdef OBD_CHECKSUM_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif
  localparam int DIV = 10;
  localparam int FRAME_CLKS = NB * 10 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1sec = 1'b0;
  logic        req = 1'b0;
  logic [3:0]  current_gear = 4'd12;
  logic [7:0]  speed = 8'd60;
  logic [13:0] rpm = 14'd1500;
  logic [7:0]  fuel = 8'd100;
  logic [7:0]  temp = 8'd50;
  logic [31:0] odometer_raw = 32'h0000_0100;
  logic        ess_trigger = 1'b0;
  logic        txd;
  logic        busy;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad = 0;
  int exp_fc = 0;
  logic [7:0] rxq [$];

  obd_telemetry_tx #(.CLK_HZ(1000), .BAUD(100), .PERIOD_TICKS(3)) dut (
    .clk(clk), .rst(rst), .tick_1sec(tick_1sec), .req(req),
    .current_gear(current_gear), .speed(speed), .rpm(rpm), .fuel(fuel),
    .temp(temp), .odometer_raw(odometer_raw), .ess_trigger(ess_trigger),
    .txd(txd), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // UART receiver: samples mid-bit, pushes each byte with a valid stop bit.
  initial begin
    logic [7:0] b;
    forever begin
      step(1);
      if (!rst && txd == 1'b0) begin
        step(DIV / 2);
        for (int k = 0; k < 8; k++) begin
          step(DIV);
          b[k] = txd;
        end
        step(DIV);
        if (txd == 1'b1) rxq.push_back(b);
      end
    end
  end

  task automatic pulse_req();
    req = 1'b1;
    step(1);
    req = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 1;
    while (busy && n < 20000) begin
      step(1);
      if (busy) n++;
    end
  endtask

  task automatic test_reset();
    step(3);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b want=1", txd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
    rst = 1'b0;
    step(5);
    total++; if (txd !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle txd=%b busy=%b want 1/0", txd, busy); end
  endtask

  task automatic test_basic();
    int n;
    logic [7:0] exp_b [13];
    exp_b = '{8'hA5, 8'h0C, 8'h3C, 8'h05, 8'hDC, 8'h64, 8'h32, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'hBE};
    rxq.delete();
    pulse_req();
    exp_fc++;
    total++; if (busy !== 1'b1 || txd !== 1'b0) begin bad++; $display("FAIL basic_start busy=%b txd=%b want 1/0", busy, txd); end
    total++; if (frame_cnt !== 16'(exp_fc)) begin bad++; $display("FAIL basic_frame_cnt got=%0d want=%0d", frame_cnt, exp_fc); end
    wait_idle(n);
    total++; if (n != FRAME_CLKS) begin bad++; $display("FAIL basic_busy_len got=%0d want=%0d", n, FRAME_CLKS); end
    step(20);
    total++;
    if (rxq.size() != NB) begin
      bad++; $display("FAIL basic_nbytes got=%0d want=%0d", rxq.size(), NB);
    end else begin
      for (int i = 0; i < NB; i++) begin
        total++;
        if (rxq[i] !== exp_b[i]) begin bad++; $display("FAIL basic_byte%0d got=%h want=%h", i, rxq[i], exp_b[i]); end
      end
    end
  endtask

  task automatic test_periodic();
    logic frame;
    for (int t = 1; t <= 7; t++) begin
      frame = (t % 3 == 0);
      speed = 8'(10 * t);
      rxq.delete();
      tick_1sec = 1'b1;
      req = (t == 6);
      step(1);
      tick_1sec = 1'b0;
      req = 1'b0;
      if (frame) exp_fc++;
      total++; if (busy !== frame) begin bad++; $display("FAIL periodic_t%0d_busy got=%b want=%b", t, busy, frame); end
      total++; if (frame_cnt !== 16'(exp_fc)) begin bad++; $display("FAIL periodic_t%0d_cnt got=%0d want=%0d", t, frame_cnt, exp_fc); end
      step(300);
      speed = 8'hEE;
      step(1700);
      total++; if (rxq.size() != (frame ? NB : 0)) begin bad++; $display("FAIL periodic_t%0d_nbytes got=%0d want=%0d", t, rxq.size(), frame ? NB : 0); end
      if (frame && rxq.size() > 2) begin
        total++; if (rxq[2] !== 8'(10 * t)) begin bad++; $display("FAIL periodic_t%0d_speed got=%h want=%h", t, rxq[2], 8'(10 * t)); end
      end
    end
    speed = 8'd60;
  endtask

  task automatic test_back_to_back();
    int n;
    rxq.delete();
    pulse_req();
    n = 1;
    while (busy && n < 20000) begin
      req = (n == 200 || n == 300 || n == 400);
      step(1);
      if (busy) n++;
    end
    req = 1'b0;
    exp_fc += 2;
    total++; if (n != 2 * FRAME_CLKS) begin bad++; $display("FAIL pending_busy_len got=%0d want=%0d", n, 2 * FRAME_CLKS); end
    total++; if (frame_cnt !== 16'(exp_fc)) begin bad++; $display("FAIL pending_frame_cnt got=%0d want=%0d", frame_cnt, exp_fc); end
    step(20);
    total++;
    if (rxq.size() != 2 * NB) begin
      bad++; $display("FAIL pending_nbytes got=%0d want=%0d", rxq.size(), 2 * NB);
    end else begin
      total++; if (rxq[NB] !== 8'hA5) begin bad++; $display("FAIL pending_hdr2 got=%h want=a5", rxq[NB]); end
      total++; if (rxq[NB + 2] !== 8'd60) begin bad++; $display("FAIL pending_speed2 got=%h want=3c", rxq[NB + 2]); end
    end
  endtask

  task automatic test_ess();
    int n;
    ess_trigger = 1'b1;
    step(1);
    ess_trigger = 1'b0;
    step(20);
    for (int f = 0; f < 2; f++) begin
      rxq.delete();
      pulse_req();
      exp_fc++;
      wait_idle(n);
      step(20);
      total++;
      if (rxq.size() != NB) begin
        bad++; $display("FAIL ess%0d_nbytes got=%0d want=%0d", f, rxq.size(), NB);
      end else begin
        total++; if (rxq[11] !== (f == 0 ? 8'h02 : 8'h00)) begin bad++; $display("FAIL ess%0d_flags got=%h want=%h", f, rxq[11], f == 0 ? 8'h02 : 8'h00); end
`ifdef OBD_CHECKSUM_EN
        total++; if (rxq[12] !== (f == 0 ? 8'hBC : 8'hBE)) begin bad++; $display("FAIL ess%0d_csum got=%h want=%h", f, rxq[12], f == 0 ? 8'hBC : 8'hBE); end
`endif
      end
    end
    total++; if (frame_cnt !== 16'(exp_fc)) begin bad++; $display("FAIL ess_frame_cnt got=%0d want=%0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_reset_mid();
    int nb;
    pulse_req();
    step(540);
    rst = 1'b1;
    #1;
    total++; if (txd !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_now txd=%b busy=%b want 1/0", txd, busy); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d want=0", frame_cnt); end
    step(3);
    rst = 1'b0;
    step(300);
    rxq.delete();
    nb = 0;
    for (int i = 0; i < 1500; i++) begin
      step(1);
      if (busy || !txd) nb++;
    end
    total++; if (nb != 0) begin bad++; $display("FAIL rstmid_resume active_cycles=%0d want=0", nb); end
    total++; if (rxq.size() != 0) begin bad++; $display("FAIL rstmid_bytes got=%0d want=0", rxq.size()); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rstmid_cnt_after got=%0d want=0", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_periodic();
    test_back_to_back();
    test_ess();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
